// File: rtl/jbu_pkg.sv
// Shared definitions for jump_branch_unit.
// Holds the operation-select codes and the flag part of the registered result.
// Optional feature macro: JBU_MISALIGN_TRAP_EN adds a trap flag to the result.
package jbu_pkg;

  localparam int unsigned OP_W = 6;

  // Operation-select codes (aluSelect)
  localparam logic [OP_W-1:0] SEL_JAL  = 6'b000011;
  localparam logic [OP_W-1:0] SEL_JALR = 6'b000100;
  localparam logic [OP_W-1:0] SEL_BEQ  = 6'b000101;
  localparam logic [OP_W-1:0] SEL_BNE  = 6'b000110;
  localparam logic [OP_W-1:0] SEL_BLT  = 6'b000111;
  localparam logic [OP_W-1:0] SEL_BGE  = 6'b001000;
  localparam logic [OP_W-1:0] SEL_BLTU = 6'b001001;
  localparam logic [OP_W-1:0] SEL_BGEU = 6'b001010;

  // Control flags of the registered result. The XLEN-wide link and target
  // fields are added by the top level, where XLEN is known.
  typedef struct packed {
    logic valid;
    logic squash;
    logic taken;
`ifdef JBU_MISALIGN_TRAP_EN
    logic trap;
`endif
  } jbu_flags_t;

endpackage

// File: rtl/jump_branch_unit_branch_compare.sv
// Combinational taken resolution for JAL/JALR and the six conditional branches.
// Ports: rs1, rs2 (compare operands), alu_select (operation), taken (result).
// Codes that are not control transfers resolve as not taken.
module branch_compare
  import jbu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned SEL_W = 6
) (
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [SEL_W-1:0] alu_select,
  output logic             taken
);

  always_comb begin
    taken = 1'b0;
    case (alu_select)
      SEL_W'(SEL_JAL),
      SEL_W'(SEL_JALR): taken = 1'b1;
      SEL_W'(SEL_BEQ):  taken = (rs1 == rs2);
      SEL_W'(SEL_BNE):  taken = (rs1 != rs2);
      SEL_W'(SEL_BLT):  taken = ($signed(rs1) <  $signed(rs2));
      SEL_W'(SEL_BGE):  taken = ($signed(rs1) >= $signed(rs2));
      SEL_W'(SEL_BLTU): taken = (rs1 <  rs2);
      SEL_W'(SEL_BGEU): taken = (rs1 >= rs2);
      default:          taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/jump_branch_unit.sv
// Execute-stage control-transfer unit: resolves JAL/JALR/branches, computes
// link (pc+4) and redirect target, registers the result behind a valid/ready
// stage and squashes wrong-path ops accepted after a taken redirect.
// Ports: clk, reset (sync, active-high); in_valid/in_ready, pc, imm, rs1, rs2,
// aluSelect (input op); flush; out_valid/out_ready, out_squash, link,
// redirect_valid, redirect_pc (registered result).
// Optional macro JBU_MISALIGN_TRAP_EN adds output misalign_trap.
module jump_branch_unit
  import jbu_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned SEL_W        = 6,
  parameter int unsigned SHADOW_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [SEL_W-1:0] aluSelect,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_squash,
  output logic [XLEN-1:0]  link,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc
`ifdef JBU_MISALIGN_TRAP_EN
  ,
  output logic             misalign_trap
`endif
);

  localparam int unsigned CNT_W = (SHADOW_DEPTH > 0) ? $clog2(SHADOW_DEPTH + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SHADOW_DEPTH);
  localparam logic             SHADOW_ON = (SHADOW_DEPTH > 0);

  typedef struct packed {
    jbu_flags_t      flags;
    logic [XLEN-1:0] link;
    logic [XLEN-1:0] target;
  } result_t;

  result_t          res_q, res_d, res_new;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             taken_c;
  logic             is_jal, is_jalr, is_branch;
  logic             accept, xfer, xfer_redirect, squash_new;
  logic [XLEN-1:0]  pc_plus4, pc_plus_imm, rs1_plus_imm;

  branch_compare #(.XLEN(XLEN), .SEL_W(SEL_W)) u_cmp (
    .rs1        (rs1),
    .rs2        (rs2),
    .alu_select (aluSelect),
    .taken      (taken_c)
  );

  // Operation decode and address arithmetic (all adds wrap modulo 2^XLEN)
  assign is_jal       = (aluSelect == SEL_W'(SEL_JAL));
  assign is_jalr      = (aluSelect == SEL_W'(SEL_JALR));
  assign is_branch    = (aluSelect >= SEL_W'(SEL_BEQ)) && (aluSelect <= SEL_W'(SEL_BGEU));
  assign pc_plus4     = pc + XLEN'(4);
  assign pc_plus_imm  = pc + imm;
  assign rs1_plus_imm = rs1 + imm;

  // Handshake
  assign in_ready      = !res_q.flags.valid || out_ready;
  assign accept        = in_valid && in_ready;
  assign xfer          = res_q.flags.valid && out_ready;
  assign xfer_redirect = xfer && redirect_valid;
  // A new op is wrong-path if the shadow is open, or a redirect leaves this cycle
  assign squash_new    = (cnt_q != '0) || (xfer_redirect && SHADOW_ON);

  // Result of the op being accepted this cycle
  always_comb begin
    res_new              = '0;
    res_new.flags.valid  = 1'b1;
    res_new.flags.squash = squash_new;
    res_new.flags.taken  = taken_c;
    if (is_jal || is_jalr) begin
      res_new.link = pc_plus4;
    end
    if (is_jalr) begin
      res_new.target = rs1_plus_imm & ~XLEN'(1);
    end else if (is_jal || (is_branch && taken_c)) begin
      res_new.target = pc_plus_imm;
    end else if (is_branch) begin
      // Not-taken branch exposes fall-through pc for visibility only
      res_new.target = pc_plus4;
    end
`ifdef JBU_MISALIGN_TRAP_EN
    res_new.flags.trap = taken_c && !squash_new && (res_new.target[1:0] != 2'b00);
`endif
  end

  // Next-state: pipeline register and shadow counter; flush dominates
  always_comb begin
    res_d = res_q;
    cnt_d = cnt_q;
    if (flush) begin
      res_d.flags.valid = 1'b0;
      cnt_d             = '0;
    end else begin
      if (accept) begin
        res_d = res_new;
      end else if (xfer) begin
        res_d.flags.valid = 1'b0;
      end
      if (accept && squash_new) begin
        cnt_d = (xfer_redirect ? CNT_FULL : cnt_q) - CNT_W'(1);
      end else if (xfer_redirect) begin
        cnt_d = CNT_FULL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_q <= '0;
      cnt_q <= '0;
    end else begin
      res_q <= res_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid   = res_q.flags.valid;
  assign out_squash  = res_q.flags.squash;
  assign link        = res_q.link;
  assign redirect_pc = res_q.target;
`ifdef JBU_MISALIGN_TRAP_EN
  assign misalign_trap  = res_q.flags.trap;
  assign redirect_valid = res_q.flags.valid && res_q.flags.taken &&
                          !res_q.flags.squash && !res_q.flags.trap;
`else
  assign redirect_valid = res_q.flags.valid && res_q.flags.taken && !res_q.flags.squash;
`endif

endmodule

// File: tb/tb_jump_branch_unit.sv
// Directed testbench for jump_branch_unit with hand-computed expectations.
module tb_jump_branch_unit;

  localparam logic [5:0] OP_NONE = 6'b000000;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_JALR = 6'b000100;
  localparam logic [5:0] OP_BEQ  = 6'b000101;
  localparam logic [5:0] OP_BNE  = 6'b000110;
  localparam logic [5:0] OP_BLT  = 6'b000111;
  localparam logic [5:0] OP_BGE  = 6'b001000;
  localparam logic [5:0] OP_BLTU = 6'b001001;
  localparam logic [5:0] OP_BGEU = 6'b001010;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] pc = '0, imm = '0, rs1 = '0, rs2 = '0;
  logic [5:0]  aluSelect = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_squash;
  logic [31:0] link;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef JBU_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  jump_branch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .pc             (pc),
    .imm            (imm),
    .rs1            (rs1),
    .rs2            (rs2),
    .aluSelect      (aluSelect),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_squash     (out_squash),
    .link           (link),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef JBU_MISALIGN_TRAP_EN
    ,
    .misalign_trap  (misalign_trap)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one op for a single accept; returns at the next falling edge
  task automatic send(input logic [5:0] sel, input logic [31:0] p, input logic [31:0] i,
                      input logic [31:0] a, input logic [31:0] b);
    aluSelect = sel; pc = p; imm = i; rs1 = a; rs2 = b;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic sq, input logic rv,
                            input logic [31:0] rpc, input logic [31:0] lnk);
    check({tag, "_ov"},  32'(out_valid), 32'd1);
    check({tag, "_sq"},  32'(out_squash), 32'(sq));
    check({tag, "_rv"},  32'(redirect_valid), 32'(rv));
    check({tag, "_rpc"}, redirect_pc, rpc);
    check({tag, "_lnk"}, link, lnk);
  endtask

  task automatic do_flush(input string tag);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check({tag, "_flush_ov"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ov",  32'(out_valid), 32'd0);
    check("rst_sq",  32'(out_squash), 32'd0);
    check("rst_lnk", link, 32'd0);
    check("rst_rpc", redirect_pc, 32'd0);
    check("rst_rv",  32'(redirect_valid), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ir", 32'(in_ready), 32'd1);

    // Basic resolution
    send(OP_JAL, 32'd100, 32'd20, 32'd0, 32'd0);
    expect_out("jal", 1'b0, 1'b1, 32'd120, 32'd104);
    do_flush("jal");
    send(OP_JALR, 32'h40, 32'd5, 32'd1023, 32'd0);
    expect_out("jalr", 1'b0, 1'b1, 32'd1028, 32'h44);
    do_flush("jalr");
    send(OP_JALR, 32'h0, 32'd7, 32'd1000, 32'd0);
    expect_out("jalr_odd", 1'b0, 1'b1, 32'd1006, 32'd4);
    do_flush("jalr_odd");
    send(OP_BEQ, 32'd200, 32'hFFFF_FFD8, 32'd7, 32'd7);
    expect_out("beq", 1'b0, 1'b1, 32'd160, 32'd0);
    do_flush("beq");
    send(OP_BNE, 32'd200, 32'hFFFF_FFD8, 32'd7, 32'd7);
    expect_out("bne_nt", 1'b0, 1'b0, 32'd204, 32'd0);
    send(OP_BLT, 32'd300, 32'd16, 32'd1, 32'hFFFF_FFFF);
    expect_out("blt_nt", 1'b0, 1'b0, 32'd304, 32'd0);
    send(OP_BLTU, 32'd300, 32'd16, 32'd1, 32'hFFFF_FFFF);
    expect_out("bltu_t", 1'b0, 1'b1, 32'd316, 32'd0);
    do_flush("bltu");
    send(OP_BGE, 32'h1000, 32'h10, 32'hFFFF_FFFB, 32'hFFFF_FFFB);
    expect_out("bge_eq", 1'b0, 1'b1, 32'h1010, 32'd0);
    do_flush("bge");
    send(OP_BGEU, 32'h1000, 32'h10, 32'd2, 32'd3);
    expect_out("bgeu_nt", 1'b0, 1'b0, 32'h1004, 32'd0);
    send(OP_NONE, 32'd500, 32'd8, 32'd1, 32'd1);
    expect_out("nonctl", 1'b0, 1'b0, 32'd0, 32'd0);
    send(OP_JAL, 32'hFFFF_FFFC, 32'd8, 32'd0, 32'd0);
    expect_out("wrap", 1'b0, 1'b1, 32'd4, 32'd0);
    do_flush("wrap");

    // Shadow: taken JAL then three back-to-back ops
    send(OP_JAL, 32'h0, 32'h40, 32'd0, 32'd0);
    expect_out("sh_jal", 1'b0, 1'b1, 32'h40, 32'h4);
    send(OP_BEQ, 32'h4, 32'h8, 32'd3, 32'd3);
    expect_out("sh_op2", 1'b1, 1'b0, 32'hC, 32'd0);
    send(OP_NONE, 32'h8, 32'h0, 32'd0, 32'd0);
    expect_out("sh_op3", 1'b1, 1'b0, 32'd0, 32'd0);
    send(OP_JAL, 32'h20, 32'h4, 32'd0, 32'd0);
    expect_out("sh_op4", 1'b0, 1'b1, 32'h24, 32'h24);
    do_flush("sh");

    // Backpressure: held result, then accept coincides with redirect transfer
    out_ready = 1'b0;
    send(OP_BNE, 32'h80, 32'h20, 32'd1, 32'd2);
    aluSelect = OP_NONE; pc = 32'h300; imm = '0; rs1 = '0; rs2 = '0;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("bp_ir", 32'(in_ready), 32'd0);
      expect_out("bp_hold", 1'b0, 1'b1, 32'hA0, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp_ir_rel", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    expect_out("bp_next", 1'b1, 1'b0, 32'd0, 32'd0);
    do_flush("bp");

    // Flush while a redirect is registered: it never opens the shadow
    send(OP_JAL, 32'h0, 32'h8, 32'd0, 32'd0);
    do_flush("fl_reg");
    send(OP_NONE, 32'h10, 32'h0, 32'd0, 32'd0);
    expect_out("fl_reg_next", 1'b0, 1'b0, 32'd0, 32'd0);
    // Flush after the redirect left with the shadow full
    send(OP_JAL, 32'h0, 32'h8, 32'd0, 32'd0);
    @(negedge clk);
    check("fl_idle_ov", 32'(out_valid), 32'd0);
    do_flush("fl_cnt");
    send(OP_BEQ, 32'h10, 32'h10, 32'd5, 32'd5);
    expect_out("fl_cnt_next", 1'b0, 1'b1, 32'h20, 32'd0);
    do_flush("fl_cnt2");
    // Flush coinciding with an accept drops the op
    aluSelect = OP_JAL; pc = 32'h0; imm = 32'h8;
    in_valid = 1'b1; flush = 1'b1;
    #1;
    check("fl_acc_ir", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("fl_acc_ov", 32'(out_valid), 32'd0);

    // Reset mid-operation clears the result and any pending redirect
    send(OP_JAL, 32'h40, 32'h10, 32'd0, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst2_ov",  32'(out_valid), 32'd0);
    check("rst2_rpc", redirect_pc, 32'd0);
    check("rst2_lnk", link, 32'd0);
    send(OP_NONE, 32'h50, 32'h0, 32'd0, 32'd0);
    expect_out("rst2_next", 1'b0, 1'b0, 32'd0, 32'd0);

`ifdef JBU_MISALIGN_TRAP_EN
    send(OP_JAL, 32'h0, 32'd6, 32'd0, 32'd0);
    check("mis_trap", 32'(misalign_trap), 32'd1);
    check("mis_rv", 32'(redirect_valid), 32'd0);
    send(OP_NONE, 32'h10, 32'h0, 32'd0, 32'd0);
    expect_out("mis_next", 1'b0, 1'b0, 32'd0, 32'd0);
    check("mis_next_trap", 32'(misalign_trap), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jump_branch_unit.md
Name: jump_branch_unit

Overview:
- Parametrised execute-stage control-transfer unit. It resolves JAL, JALR and the six conditional branches, and computes the link value (pc+4) and the redirect target.
- Registers the result in one pipeline stage with valid/ready handshake. Drives the fetch redirect.
- After a taken redirect, squashes the wrong-path instructions that were already in flight, using a shadow counter.

Parameters:
- XLEN, 32, datapath width for pc, imm, rs1, rs2, target and link.
- SEL_W, 6, width of aluSelect.
- SHADOW_DEPTH, 2, number of younger accepted instructions squashed after a taken redirect (0 disables squashing).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  upstream op present.
- in_ready  output  1  unit can accept this cycle.
- pc  input  XLEN  pc of op.
- imm  input  XLEN  sign-extended immediate.
- rs1  input  XLEN  operand 1 (JALR base, branch compare).
- rs2  input  XLEN  operand 2 (branch compare).
- aluSelect  input  SEL_W  operation select.
- flush  input  1  kill the registered op and clear the shadow.
- out_valid  output  1  registered result valid.
- out_ready  input  1  downstream accepts.
- out_squash  output  1  registered op is wrong-path; writeback must be suppressed.
- link  output  XLEN  pc+4 for JAL/JALR, otherwise 0.
- redirect_valid  output  1  out_valid & taken & !out_squash.
- redirect_pc  output  XLEN  resolved target.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: out_valid=0, out_squash=0, link=0, redirect_pc=0, shadow counter=0. in_ready=1 in the first cycle after reset.
- Handshake:
  - in_ready = !out_valid | out_ready.
  - Accept occurs on in_valid & in_ready. Output transfer occurs on out_valid & out_ready.
  - On accept, the register loads the result one cycle later (latency 1).
  - Output values are held stable while out_valid & !out_ready.
- Operations (aluSelect):
  - JAL 000011: target = pc+imm, always taken.
  - JALR 000100: target = (rs1+imm) & ~1, always taken.
  - BEQ 000101, BNE 000110: target = pc+imm, taken per equality compare.
  - BLT 000111, BGE 001000: signed compare.
  - BLTU 001001, BGEU 001010: unsigned compare.
  - Any other code: not a control transfer. taken=0, redirect_pc=0, link=0, and the op still passes through the handshake.
- Arithmetic: all adds are modulo 2^XLEN (wrap, no overflow flag). Negative imm is handled by two's complement.
- Not-taken branch: redirect_pc = pc+4 for visibility, but redirect_valid=0.
- Shadow counter (0..SHADOW_DEPTH):
  - Loaded with SHADOW_DEPTH when a taken, non-squashed op transfers out.
  - Each later accept while the counter is >0 loads out_squash=1 and decrements the counter.
  - A squashed op never redirects and never reloads the counter.
- Simultaneous events:
  - Redirect transfer and new accept in the same cycle: the new op is the first squashed one, and the counter is loaded with SHADOW_DEPTH-1.
  - flush: out_valid←0 and counter←0 next cycle, with priority over accept and transfer. in_ready still follows the handshake equation for that cycle, but an accepted op is dropped.
- reset mid-operation: identical to the reset values above. Any pending redirect is lost.

Optional Feature:
- Macro: JBU_MISALIGN_TRAP_EN.
- With the macro defined:
  - Extra output port misalign_trap (1 bit).
  - A taken, non-squashed op with target[1:0]≠0 sets misalign_trap=1 in the registered result.
  - That op has redirect_valid=0 and does not load the shadow counter.
  - misalign_trap resets to 0.
- Without the macro: the port is absent, and a misaligned target redirects normally (JALR still clears bit 0).

Decomposition:
- Package jbu_pkg holds:
  - The aluSelect localparams (JAL, JALR, BEQ..BGEU).
  - A typedef for the registered result struct: valid, squash, taken, link, target, optional trap.
- Sub-module branch_compare: combinational, parametrised on XLEN; takes rs1, rs2 and aluSelect and produces taken.
- The top level holds the pipeline register, the handshake and the shadow counter.

Test Plan:
- JAL: pc=100, imm=20, out_ready=1 → one cycle later redirect_valid=1, redirect_pc=120, link=104.
- JALR odd sum: rs1=1023, imm=5 → redirect_pc=1028. BEQ with rs1=rs2=7, pc=200, imm=-40 → redirect_pc=160, link=0.
- Shadow, SHADOW_DEPTH=2: a taken JAL followed by three back-to-back ops → ops 2–3 have out_squash=1, op 4 has out_squash=0. A taken branch among the squashed ops produces no redirect.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 → in_ready=0 and outputs stable; the op transfers once out_ready=1.
- flush while out_valid=1 and counter=2 → next cycle out_valid=0 and counter=0; the next accepted op is not squashed.
- With JBU_MISALIGN_TRAP_EN: JAL pc=0, imm=6 → misalign_trap=1, redirect_valid=0. BLTU rs1=1, rs2=0xFFFFFFFF → taken; BLT with the same operands → not taken.
